// File: rtl/matmul_pkg.sv
// Shared defaults, element/matrix types and scheduler state encoding
// for the matrix-add datapath and its request scheduler.
package matmul_pkg;

    localparam int BIT_PREC = 8;
    localparam int N        = 2;

    typedef logic signed [N-1:0][N-1:0][BIT_PREC-1:0] mat_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } sched_state_t;

endpackage

// File: rtl/matadd_2x2.sv
// Combinational 2x2 element-wise adder; each sum wraps modulo 2^BIT_PREC.
module matadd_2x2 #(
    parameter int BIT_PREC = 8
) (
    input  logic [1:0][1:0][BIT_PREC-1:0] a,
    input  logic [1:0][1:0][BIT_PREC-1:0] b,
    output logic [1:0][1:0][BIT_PREC-1:0] c
);

    always_comb begin
        c = '0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 2; k++) begin
                c[r][k] = a[r][k] + b[r][k];
            end
        end
    end

endmodule

// File: rtl/matadd_scheduler_arbiter.sv
// Round-robin arbiter: the search starts at ptr and wraps; grant is gated by en
// while grant_idx always reports the winner (if any) for the data mux.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx
);

    logic found;
    int   j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant_idx = ID_W'(j);
            end
        end
        if (en && found) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/matadd_scheduler.sv
// Shares one matadd_2x2 between N_REQ requesters: round-robin accept,
// one ADD cycle, then a held response carrying the sum, owner ID and overflow.
module matadd_scheduler #(
    parameter int BIT_PREC = matmul_pkg::BIT_PREC,
    parameter int N        = matmul_pkg::N,
    parameter int N_REQ    = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [N_REQ-1:0]                             req_valid,
    output logic [N_REQ-1:0]                             req_ready,
    input  logic [N_REQ-1:0][N-1:0][N-1:0][BIT_PREC-1:0] req_a,
    input  logic [N_REQ-1:0][N-1:0][N-1:0][BIT_PREC-1:0] req_b,
    output logic                                         resp_valid,
    input  logic                                         resp_ready,
    output logic [$clog2(N_REQ)-1:0]                     resp_id,
    output logic [N-1:0][N-1:0][BIT_PREC-1:0]            resp_c,
    output logic                                         resp_ovf,
    output logic                                         busy
);

    import matmul_pkg::*;

    localparam int ID_W = $clog2(N_REQ);

    generate
        if (N != 2) begin : g_bad_n
            $error("matadd_scheduler: N must be 2 (matadd_2x2 datapath)");
        end
        if (N_REQ < 2) begin : g_bad_nreq
            $error("matadd_scheduler: N_REQ must be at least 2");
        end
    endgenerate

    sched_state_t                      state, state_nxt;
    logic [ID_W-1:0]                   ptr;
    logic [ID_W-1:0]                   op_id;
    logic [N-1:0][N-1:0][BIT_PREC-1:0] op_a, op_b, sum;
    logic [N_REQ-1:0]                  grant;
    logic [ID_W-1:0]                   grant_idx;
    logic                              can_accept;
    logic                              accept;
    logic                              ovf;

    // Reset is excluded so a requester held valid through reset is never acked.
    assign can_accept = !rst && ((state == IDLE) || (state == RESP && resp_ready));

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .en        (can_accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready  = grant;
    assign accept     = |grant;
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

    matadd_2x2 #(
        .BIT_PREC (BIT_PREC)
    ) u_add (
        .a (op_a),
        .b (op_b),
        .c (sum)
    );

    // Signed overflow: operands agree in sign but the wrapped sum does not.
    always_comb begin
        ovf = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < N; k++) begin
                if ((op_a[r][k][BIT_PREC-1] == op_b[r][k][BIT_PREC-1]) &&
                    (sum[r][k][BIT_PREC-1] != op_a[r][k][BIT_PREC-1]))
                    ovf = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ADD;
            ADD:     state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = accept ? ADD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            op_id    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            resp_c   <= '0;
            resp_ovf <= 1'b0;
            resp_id  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_a  <= req_a[grant_idx];
                op_b  <= req_b[grant_idx];
                op_id <= grant_idx;
                ptr   <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            end
            if (state == ADD) begin
                resp_c   <= sum;
                resp_ovf <= ovf;
                resp_id  <= op_id;
            end
        end
    end

endmodule

// File: tb/tb_matadd_scheduler.sv
// Randomized self-checking bench for matadd_scheduler with a transaction-level
// round-robin / signed-add reference model.
module tb_matadd_scheduler;

    typedef logic [1:0][1:0][7:0] tmat_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [3:0]            req_valid = '0;
    logic [3:0]            req_ready;
    logic [3:0][1:0][1:0][7:0] req_a = '0;
    logic [3:0][1:0][1:0][7:0] req_b = '0;
    logic                  resp_valid;
    logic                  resp_ready = 1'b0;
    logic [1:0]            resp_id;
    logic [1:0][1:0][7:0]  resp_c;
    logic                  resp_ovf;
    logic                  busy;

    int errors = 0;
    int checks = 0;
    int p_model = 0;
    int grant_log[$];

    matadd_scheduler #(.BIT_PREC(8), .N(2), .N_REQ(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_c     (resp_c),
        .resp_ovf   (resp_ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic tmat_t add_ref(tmat_t a, tmat_t b);
        tmat_t res;
        int s;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 2; k++) begin
                s = int'($signed(a[r][k])) + int'($signed(b[r][k]));
                res[r][k] = 8'(s);
            end
        return res;
    endfunction

    function automatic bit ovf_ref(tmat_t a, tmat_t b);
        bit o = 1'b0;
        int s;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 2; k++) begin
                s = int'($signed(a[r][k])) + int'($signed(b[r][k]));
                if (s > 127 || s < -128) o = 1'b1;
            end
        return o;
    endfunction

    function automatic int rr_pick(int p, logic [3:0] v);
        int i;
        for (int k = 0; k < 4; k++) begin
            i = (p + k) % 4;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v == (4'b0001 << i)) return i;
        return -1;
    endfunction

    function automatic logic [7:0] rand_elem();
        case ($urandom_range(0, 5))
            0:       return 8'h7f;
            1:       return 8'h80;
            2:       return 8'hff;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic load_random(int i);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 2; k++) begin
                req_a[i][r][k] = rand_elem();
                req_b[i][r][k] = rand_elem();
            end
    endtask

    // Serves n_ops grants from the requesters in mask with resp_ready held high.
    task automatic run_stream(logic [3:0] mask, int n_ops, bit keep);
        int    g;
        int    obs;
        tmat_t exp_c;
        bit    exp_o;
        logic [3:0] exp_rdy;
        grant_log.delete();
        resp_ready = 1'b1;
        req_valid  = mask;
        #1;
        for (int n = 0; n < n_ops; n++) begin
            g = rr_pick(p_model, req_valid);
            exp_rdy = (g < 0) ? 4'b0000 : (4'b0001 << g);
            obs = onehot_idx(req_ready);
            grant_log.push_back(obs);
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL stream_grant: req_ready=%b expected %b", req_ready, exp_rdy);
            end
            if (g < 0) break;
            exp_c   = add_ref(req_a[g], req_b[g]);
            exp_o   = ovf_ref(req_a[g], req_b[g]);
            p_model = (g + 1) % 4;
            tick();
            if (keep) load_random(g);
            else req_valid[g] = 1'b0;
            #1;
            checks++;
            if (resp_valid !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stream_add_cycle: resp_valid=%b req_ready=%b busy=%b expected 0 0000 1",
                         resp_valid, req_ready, busy);
            end
            tick();
            checks++;
            if (resp_valid !== 1'b1 || resp_c !== exp_c || resp_id !== 2'(g) || resp_ovf !== exp_o) begin
                errors++;
                $display("FAIL stream_resp: valid=%b c=%h id=%0d ovf=%b expected 1 %h %0d %b",
                         resp_valid, resp_c, resp_id, resp_ovf, exp_c, g, exp_o);
            end
        end
        req_valid = '0;
        tick();
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_idle: busy=%b resp_valid=%b expected 0 0", busy, resp_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b1111;
        load_random(0);
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000 || resp_valid !== 1'b0 || busy !== 1'b0 ||
            resp_c !== '0 || resp_id !== 2'd0 || resp_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b valid=%b busy=%b c=%h id=%0d ovf=%b expected all zero",
                     req_ready, resp_valid, busy, resp_c, resp_id, resp_ovf);
        end
        req_valid = '0;
        rst = 1'b0;
        p_model = 0;
        tick();
        tick();
        checks++;
        if (req_ready !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_request: req_ready=%b busy=%b expected 0000 0", req_ready, busy);
        end
    endtask

    task automatic test_fairness();
        for (int i = 0; i < 4; i++) load_random(i);
        run_stream(4'b1111, 8, 1'b1);
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (grant_log.size() <= n || grant_log[n] != n % 4) begin
                errors++;
                $display("FAIL fairness_order[%0d]: got %0d expected %0d",
                         n, (grant_log.size() > n) ? grant_log[n] : -1, n % 4);
            end
        end
    endtask

    task automatic test_single();
        req_a[0] = {8'd4, 8'd3, 8'd2, 8'd1};
        req_b[0] = {8'd8, 8'd7, 8'd6, 8'd5};
        run_stream(4'b0001, 1, 1'b0);
        checks++;
        if (resp_c !== {8'd12, 8'd10, 8'd8, 8'd6} || resp_id !== 2'd0 || resp_ovf !== 1'b0) begin
            errors++;
            $display("FAIL single_op: c=%h id=%0d ovf=%b expected 0c0a0806 0 0", resp_c, resp_id, resp_ovf);
        end
    endtask

    task automatic test_overflow();
        req_a[1] = '0;
        req_b[1] = '0;
        req_a[1][0][0] = 8'd100;
        req_b[1][0][0] = 8'd50;
        run_stream(4'b0010, 1, 1'b0);
        checks++;
        if (resp_c[0][0] !== 8'h96 || resp_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_pos: c00=%h ovf=%b expected 96 1", resp_c[0][0], resp_ovf);
        end
        req_a[1] = '0;
        req_b[1] = '0;
        req_a[1][1][1] = 8'h80;
        req_b[1][1][1] = 8'hff;
        run_stream(4'b0010, 1, 1'b0);
        checks++;
        if (resp_c[1][1] !== 8'h7f || resp_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_neg: c11=%h ovf=%b expected 7f 1", resp_c[1][1], resp_ovf);
        end
    endtask

    task automatic test_backpressure();
        tmat_t exp_c;
        bit    exp_o;
        int    g;
        resp_ready = 1'b0;
        load_random(1);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_first_grant: req_ready=%b expected 0010", req_ready);
        end
        exp_c = add_ref(req_a[1], req_b[1]);
        exp_o = ovf_ref(req_a[1], req_b[1]);
        p_model = 2;
        tick();
        req_valid = '0;
        tick();
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (cyc < 2) req_valid[0] = 1'b1;
            else begin
                req_valid[0] = 1'b0;
                if (cyc == 2) load_random(3);
                req_valid[3] = 1'b1;
            end
            #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_c !== exp_c || resp_id !== 2'd1 ||
                resp_ovf !== exp_o || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b c=%h id=%0d ovf=%b rdy=%b expected 1 %h 1 %b 0000",
                         cyc, resp_valid, resp_c, resp_id, resp_ovf, req_ready, exp_c, exp_o);
            end
            tick();
        end
        resp_ready = 1'b1;
        #1;
        g = rr_pick(p_model, req_valid);
        checks++;
        if (req_ready !== 4'b1000 || g != 3) begin
            errors++;
            $display("FAIL bp_release_grant: req_ready=%b expected 1000", req_ready);
        end
        exp_c = add_ref(req_a[3], req_b[3]);
        exp_o = ovf_ref(req_a[3], req_b[3]);
        p_model = 0;
        tick();
        req_valid = '0;
        tick();
        checks++;
        if (resp_valid !== 1'b1 || resp_c !== exp_c || resp_id !== 2'd3 || resp_ovf !== exp_o) begin
            errors++;
            $display("FAIL bp_second_resp: valid=%b c=%h id=%0d ovf=%b expected 1 %h 3 %b",
                     resp_valid, resp_c, resp_id, resp_ovf, exp_c, exp_o);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_pointer_skip();
        load_random(2);
        run_stream(4'b0100, 1, 1'b0);
        checks++;
        if (grant_log[0] != 2) begin
            errors++;
            $display("FAIL skip_first: grant=%0d expected 2", grant_log[0]);
        end
        load_random(1);
        load_random(3);
        run_stream(4'b1010, 2, 1'b0);
        checks++;
        if (grant_log.size() != 2 || grant_log[0] != 3 || grant_log[1] != 1) begin
            errors++;
            $display("FAIL skip_order: grants=%0d,%0d expected 3,1",
                     grant_log[0], (grant_log.size() > 1) ? grant_log[1] : -1);
        end
    endtask

    task automatic test_random();
        logic [3:0] mask;
        for (int t = 0; t < 10; t++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) load_random(i);
            run_stream(mask, $urandom_range(1, $countones(mask)), 1'b0);
        end
        for (int i = 0; i < 4; i++) load_random(i);
        run_stream(4'b1111, 12, 1'b1);
    endtask

    task automatic test_reset_mid_op();
        resp_ready = 1'b1;
        load_random(2);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL rst_op_grant: req_ready=%b expected 0100", req_ready);
        end
        tick();
        req_valid = '0;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || resp_c !== '0 || resp_id !== 2'd0 || resp_ovf !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_op: busy=%b valid=%b c=%h id=%0d ovf=%b expected all zero",
                     busy, resp_valid, resp_c, resp_id, resp_ovf);
        end
        tick();
        rst = 1'b0;
        p_model = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            tick();
            checks++;
            if (resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_resp[%0d]: resp_valid=%b expected 0", cyc, resp_valid);
            end
        end
        for (int i = 0; i < 4; i++) load_random(i);
        run_stream(4'b1111, 4, 1'b1);
        checks++;
        if (grant_log[0] != 0) begin
            errors++;
            $display("FAIL rst_first_grant: grant=%0d expected 0", grant_log[0]);
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_overflow();
        test_backpressure();
        test_pointer_skip();
        test_random();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
